// File: rtl/alu_pkg.sv
// alu_pkg: nibble width, adder FSM state encoding and op encoding shared with the ALU control
package alu_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/nibble_adder.sv
// nibble_adder: combinational 4-bit ripple adder stage with carry in/out
module nibble_adder
  import alu_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add/sub through one 4-bit stage, one nibble per clock, LSB first.
// Define NIBBLE_SERIAL_ADDER_FLAGS_EN to add the overflow and zero flag outputs.
module nibble_serial_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int NIBBLES = WIDTH / NIBBLE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
  ,
  output logic             overflow,
  output logic             zero
`endif
);
  localparam int IW = $clog2(NIBBLES);
  state_t state;
  logic [WIDTH-1:0] op_a, op_b;
  logic [IW-1:0] idx;
  logic carry, ncout, last;
  logic [NIBBLE_W-1:0] nsum;
  logic [WIDTH-1:0] next_result;

  nibble_adder u_add (
    .a   (op_a[NIBBLE_W-1:0]),
    .b   (op_b[NIBBLE_W-1:0]),
    .cin (carry),
    .sum (nsum),
    .cout(ncout)
  );

  // operands shift right so the active nibble is always at the bottom; the sum shifts in from the top
  assign next_result = {nsum, result[WIDTH-1:NIBBLE_W]};
  assign last = state == RUN && idx == IW'(NIBBLES - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            op_a  <= a;
            op_b  <= sub == OP_SUB ? ~b : b;
            carry <= sub;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          op_a   <= op_a >> NIBBLE_W;
          op_b   <= op_b >> NIBBLE_W;
          carry  <= ncout;
          result <= next_result;
          idx    <= idx + IW'(1);
          if (last) begin
            cout  <= ncout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
  // on the last nibble the bottom nibble of each operand holds its sign bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (last) begin
      overflow <= op_a[NIBBLE_W-1] == op_b[NIBBLE_W-1] && nsum[NIBBLE_W-1] != op_a[NIBBLE_W-1];
      zero     <= next_result == '0;
    end
  end
`endif
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic sub = 1'b0;
  logic busy, done, cout;
  logic [31:0] result;
`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
  logic overflow, zero;
`endif
  int total = 0;
  int bad = 0;
  int n;
  int pulses;

  nibble_serial_adder #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .result(result),
    .cout  (cout)
`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
    ,
    .overflow(overflow),
    .zero    (zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic s);
    @(negedge clk);
    a = x;
    b = y;
    sub = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic count_pulses(input int len, output int cnt);
    cnt = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
  endtask

  initial begin
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    start_op(32'h0000_0001, 32'h0000_0007, 1'b0);
    check("add_busy", {31'd0, busy}, 32'd1);
    wait_done(n);
    check("add_latency", n, 32'd8);
    check("add_result", result, 32'h0000_0008);
    check("add_cout", {31'd0, cout}, 32'd0);
    check("add_busy_at_done", {31'd0, busy}, 32'd0);
`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
    check("add_ovf", {31'd0, overflow}, 32'd0);
    check("add_zero", {31'd0, zero}, 32'd0);
`endif
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("result_held", result, 32'h0000_0008);

    start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done(n);
    check("wrap_result", result, 32'h0000_0000);
    check("wrap_cout", {31'd0, cout}, 32'd1);
`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
    check("wrap_zero", {31'd0, zero}, 32'd1);
    check("wrap_ovf", {31'd0, overflow}, 32'd0);
`endif

    start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done(n);
    check("sovf_result", result, 32'h8000_0000);
    check("sovf_cout", {31'd0, cout}, 32'd0);
`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
    check("sovf_ovf", {31'd0, overflow}, 32'd1);
    check("sovf_zero", {31'd0, zero}, 32'd0);
`endif

    start_op(32'd5, 32'd7, 1'b1);
    wait_done(n);
    check("sub57_result", result, 32'hFFFF_FFFE);
    check("sub57_cout", {31'd0, cout}, 32'd0);
`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
    check("sub57_ovf", {31'd0, overflow}, 32'd0);
`endif
    start_op(32'd7, 32'd5, 1'b1);
    wait_done(n);
    check("sub75_result", result, 32'h0000_0002);
    check("sub75_cout", {31'd0, cout}, 32'd1);

    start_op(32'h0000_0010, 32'h0000_0020, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a = 32'h1111_1111;
    b = 32'h0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 32'hDEAD_BEEF;
    check("busy_mid_run", {31'd0, busy}, 32'd1);
    wait_done(n);
    check("ignored_latency", n, 32'd5);
    check("ignored_result", result, 32'h0000_0030);
    count_pulses(12, pulses);
    check("ignored_no_second_done", pulses, 32'd0);
    check("ignored_idle_busy", {31'd0, busy}, 32'd0);

    start_op(32'd3, 32'd4, 1'b0);
    wait_done(n);
    check("pre_done_result", result, 32'd7);
    a = 32'h100;
    b = 32'h200;
    sub = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_start_busy", {31'd0, busy}, 32'd1);
    check("done_start_done_low", {31'd0, done}, 32'd0);
    wait_done(n);
    check("done_start_latency", n, 32'd8);
    check("done_start_result", result, 32'h300);

    start_op(32'h1234_5678, 32'h0000_0001, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_pulses(12, pulses);
    check("mid_rst_no_done", pulses, 32'd0);
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_done(n);
    check("post_rst_latency", n, 32'd8);
    check("post_rst_result", result, 32'h2345_6789);
    check("post_rst_cout", {31'd0, cout}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
